// File: rtl/cpu_types_pkg.sv
// Shared types for the snooping coherence arbiter: memory status, FSM state, address helper.
// No logic, no latency.
// No flow control; types only.
package cpu_types_pkg;

  // Memory port status as reported by the RAM controller
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    XFER  = 2'd2,
    MEM   = 2'd3
  } arb_state_t;

  // Byte address of word k inside a block; wraps modulo 2^32
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [1:0] k);
    return base + {28'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/coherence_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  localparam logic [IW:0] NWRAP = (IW+1)'(N);

  // Scan from the pointer upward, wrapping at N, and stop at the first requester
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NWRAP) sum = sum - NWRAP;
      cand = sum[IW-1:0];
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherence_arbiter.sv
// Bus arbiter for snooping caches: grants one requester, snoops the others, fills from a peer or memory.
// Latency: 1 cycle arbitration + 1 cycle snoop + one RAM ACCESS cycle per block word.
// Stalls the requester via dwait while RAM is BUSY/ERROR; other requests wait in IDLE.
module coherence_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCORES      = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        cctrans,
  input  logic [NCORES-1:0]        ccwrite,
  input  logic [NCORES-1:0][31:0]  daddr,
  input  logic [NCORES-1:0][31:0]  dstore,
  output logic [NCORES-1:0]        dwait,
  output logic [NCORES-1:0][31:0]  dload,
  output logic [NCORES-1:0]        ccwait,
  output logic [NCORES-1:0]        ccinv,
  output logic [NCORES-1:0][31:0]  ccsnoopaddr,
  input  ramstate_t                ramstate,
  input  logic [31:0]              ramload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [31:0]              ramaddr,
  output logic [31:0]              ramstore,
  output logic                     c2c,
  output logic [NCORES-1:0]        grant
);

  localparam int            IW    = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [1:0]    KLAST = 2'(BLOCK_WORDS - 1);
  localparam logic [IW-1:0] ILAST = IW'(NCORES - 1);

  arb_state_t        state;
  logic [IW-1:0]     rr;
  logic [1:0]        k;
  logic [IW-1:0]     req_idx;
  logic [IW-1:0]     sup_idx;
  logic [NCORES-1:0] gnt_q;
  logic              lwrite;
  logic [31:0]       laddr;

  logic [NCORES-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_vld;
  logic              sup_found;
  logic [IW-1:0]     sup_sel;
  logic [31:0]       cur_addr;
  logic              word_done;

  rr_arbiter #(.N(NCORES), .IW(IW)) u_rr (
    .req (cctrans),
    .ptr (rr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign cur_addr  = word_addr(laddr, k);
  // ERROR deliberately counts as not-ready, same as BUSY
  assign word_done = (ramstate == ACCESS);

  // Lowest-index peer holding the block Modified (snoop hit, not itself requesting)
  always_comb begin
    sup_found = 1'b0;
    sup_sel   = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (IW'(i) != req_idx && ccwrite[i] && !cctrans[i]) begin
        sup_found = 1'b1;
        sup_sel   = IW'(i);
      end
    end
  end

  // Transaction FSM: arbitrate, snoop one cycle, then move BLOCK_WORDS words
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      rr      <= '0;
      k       <= '0;
      req_idx <= '0;
      sup_idx <= '0;
      gnt_q   <= '0;
      lwrite  <= 1'b0;
      laddr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            req_idx <= arb_idx;
            gnt_q   <= arb_gnt;
            lwrite  <= ccwrite[arb_idx];
            laddr   <= daddr[arb_idx];
            rr      <= (arb_idx == ILAST) ? '0 : arb_idx + 1'b1;
            state   <= SNOOP;
          end
        end
        SNOOP: begin
          sup_idx <= sup_sel;
          state   <= sup_found ? XFER : MEM;
        end
        XFER, MEM: begin
          if (word_done) begin
            if (k == KLAST) begin
              k     <= '0;
              state <= IDLE;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus, cache-control and memory outputs decoded from the current phase
  always_comb begin
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    c2c         = 1'b0;
    grant       = '0;
    case (state)
      SNOOP: begin
        grant = gnt_q;
        for (int i = 0; i < NCORES; i++) begin
          if (IW'(i) != req_idx) begin
            ccwait[i]      = 1'b1;
            ccinv[i]       = lwrite;
            ccsnoopaddr[i] = laddr;
          end
        end
      end
      XFER: begin
        grant                = gnt_q;
        c2c                  = 1'b1;
        ramWEN               = 1'b1;
        ramaddr              = cur_addr;
        ramstore             = dstore[sup_idx];
        dload[req_idx]       = dstore[sup_idx];
        dwait[req_idx]       = !word_done;
        ccwait[sup_idx]      = 1'b1;
        ccinv[sup_idx]       = lwrite;
        ccsnoopaddr[sup_idx] = cur_addr;
      end
      MEM: begin
        grant          = gnt_q;
        ramREN         = 1'b1;
        ramaddr        = cur_addr;
        dload[req_idx] = ramload;
        dwait[req_idx] = !word_done;
        for (int i = 0; i < NCORES; i++) begin
          if (IW'(i) != req_idx) begin
            ccwait[i]      = 1'b1;
            ccinv[i]       = lwrite;
            ccsnoopaddr[i] = cur_addr;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_arbiter.sv
// Directed bench: two-core instance for fills, snoops, reset and stalls; four-core instance for fairness.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
// Each step is a fixed number of cycles, so the run always terminates.
module tb_coherence_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;

  // two-core instance
  logic [1:0]       cctrans2, ccwrite2, dwait2, ccwait2, ccinv2, grant2;
  logic [1:0][31:0] daddr2, dstore2, dload2, ccsnoopaddr2;
  ramstate_t        ramstate2;
  logic [31:0]      ramload2, ramaddr2, ramstore2;
  logic             ramREN2, ramWEN2, c2c2;

  // four-core instance
  logic [3:0]       cctrans4, ccwrite4, dwait4, ccwait4, ccinv4, grant4;
  logic [3:0][31:0] daddr4, dstore4, dload4, ccsnoopaddr4;
  ramstate_t        ramstate4;
  logic [31:0]      ramload4, ramaddr4, ramstore4;
  logic             ramREN4, ramWEN4, c2c4;

  int checks = 0;
  int errors = 0;

  coherence_arbiter #(.NCORES(2), .BLOCK_WORDS(2)) u2 (
    .CLK(CLK), .nRST(nRST), .cctrans(cctrans2), .ccwrite(ccwrite2), .daddr(daddr2),
    .dstore(dstore2), .dwait(dwait2), .dload(dload2), .ccwait(ccwait2), .ccinv(ccinv2),
    .ccsnoopaddr(ccsnoopaddr2), .ramstate(ramstate2), .ramload(ramload2), .ramREN(ramREN2),
    .ramWEN(ramWEN2), .ramaddr(ramaddr2), .ramstore(ramstore2), .c2c(c2c2), .grant(grant2)
  );

  coherence_arbiter #(.NCORES(4), .BLOCK_WORDS(2)) u4 (
    .CLK(CLK), .nRST(nRST), .cctrans(cctrans4), .ccwrite(ccwrite4), .daddr(daddr4),
    .dstore(dstore4), .dwait(dwait4), .dload(dload4), .ccwait(ccwait4), .ccinv(ccinv4),
    .ccsnoopaddr(ccsnoopaddr4), .ramstate(ramstate4), .ramload(ramload4), .ramREN(ramREN4),
    .ramWEN(ramWEN4), .ramaddr(ramaddr4), .ramstore(ramstore4), .c2c(c2c4), .grant(grant4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    nRST      = 1'b0;
    cctrans2  = '0; ccwrite2 = '0; daddr2 = '0; dstore2 = '0;
    ramstate2 = FREE; ramload2 = '0;
    cctrans4  = '0; ccwrite4 = '0; daddr4 = '0; dstore4 = '0;
    ramstate4 = FREE; ramload4 = '0;

    // reset state
    step(); #1;
    chk("rst_grant", 32'(grant2), 32'h0);
    chk("rst_dwait", 32'(dwait2), 32'h3);
    chk("rst_ren_wen", {30'd0, ramREN2, ramWEN2}, 32'h0);
    chk("rst_ccwait", 32'(ccwait2), 32'h0);
    nRST = 1'b1;

    // core0 BusRd 0x100, no peer hit -> memory fill, 5 BUSY cycles first
    cctrans2 = 2'b01; ccwrite2 = 2'b00; daddr2[0] = 32'h100;
    #1;
    chk("rd_idle_grant", 32'(grant2), 32'h0);
    step(); #1;
    chk("rd_snoop_grant", 32'(grant2), 32'h1);
    chk("rd_snoop_ccwait", 32'(ccwait2), 32'h2);
    chk("rd_snoop_ccinv", 32'(ccinv2), 32'h0);
    chk("rd_snoop_addr1", ccsnoopaddr2[1], 32'h100);
    chk("rd_snoop_dwait", 32'(dwait2), 32'h3);
    ramstate2 = BUSY;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("busy_dwait", 32'(dwait2), 32'h3);
      chk("busy_ramaddr", ramaddr2, 32'h100);
      chk("busy_ren", {31'd0, ramREN2}, 32'h1);
    end
    ramstate2 = ACCESS; ramload2 = 32'hA;
    #1;
    chk("mem_w0_dwait", 32'(dwait2), 32'h2);
    chk("mem_w0_dload", dload2[0], 32'hA);
    chk("mem_w0_dload1", dload2[1], 32'h0);
    step(); ramload2 = 32'hB; #1;
    chk("mem_w1_ramaddr", ramaddr2, 32'h104);
    chk("mem_w1_dload", dload2[0], 32'hB);
    chk("mem_w1_dwait", 32'(dwait2), 32'h2);
    chk("mem_w1_snoopaddr", ccsnoopaddr2[1], 32'h104);
    chk("mem_wen", {31'd0, ramWEN2}, 32'h0);
    step(); cctrans2 = 2'b00; ramstate2 = FREE; #1;
    chk("mem_done_grant", 32'(grant2), 32'h0);
    chk("mem_done_dwait", 32'(dwait2), 32'h3);
    chk("mem_done_ren", {31'd0, ramREN2}, 32'h0);

    // core1 BusRdX 0x200 while core0 holds it Modified -> cache-to-cache
    cctrans2 = 2'b10; ccwrite2 = 2'b11; daddr2[1] = 32'h200; dstore2[0] = 32'hDEAD0001;
    step(); #1;
    chk("x_snoop_grant", 32'(grant2), 32'h2);
    chk("x_snoop_ccinv", 32'(ccinv2), 32'h1);
    chk("x_snoop_ccwait", 32'(ccwait2), 32'h1);
    chk("x_snoop_addr0", ccsnoopaddr2[0], 32'h200);
    ramstate2 = ACCESS;
    step(); #1;
    chk("x_w0_wen_ren", {30'd0, ramWEN2, ramREN2}, 32'h2);
    chk("x_w0_ramaddr", ramaddr2, 32'h200);
    chk("x_w0_c2c", {31'd0, c2c2}, 32'h1);
    chk("x_w0_ramstore", ramstore2, 32'hDEAD0001);
    chk("x_w0_dload1", dload2[1], 32'hDEAD0001);
    chk("x_w0_dwait", 32'(dwait2), 32'h1);
    chk("x_w0_ccinv", 32'(ccinv2), 32'h1);
    step(); dstore2[0] = 32'hDEAD0002; #1;
    chk("x_w1_ramaddr", ramaddr2, 32'h204);
    chk("x_w1_dload1", dload2[1], 32'hDEAD0002);
    chk("x_w1_snoopaddr0", ccsnoopaddr2[0], 32'h204);
    step(); cctrans2 = 2'b00; ccwrite2 = 2'b00; ramstate2 = FREE; #1;
    chk("x_done_c2c", {31'd0, c2c2}, 32'h0);
    chk("x_done_wen", {31'd0, ramWEN2}, 32'h0);

    // reset in the middle of a transfer; rr must return to 0
    cctrans2 = 2'b01; ccwrite2 = 2'b10; daddr2[0] = 32'h300; dstore2[1] = 32'h1234;
    step(); ramstate2 = BUSY; #1;
    chk("r_snoop_grant", 32'(grant2), 32'h1);
    step(); #1;
    chk("r_xfer_wen", {31'd0, ramWEN2}, 32'h1);
    chk("r_xfer_ramaddr", ramaddr2, 32'h300);
    nRST = 1'b0; #1;
    chk("r_rst_wen", {31'd0, ramWEN2}, 32'h0);
    chk("r_rst_grant", 32'(grant2), 32'h0);
    chk("r_rst_c2c", {31'd0, c2c2}, 32'h0);
    chk("r_rst_dwait", 32'(dwait2), 32'h3);
    step(); nRST = 1'b1; cctrans2 = 2'b11; ccwrite2 = 2'b00; ramstate2 = ACCESS;
    step(); #1;
    chk("r_after_grant", 32'(grant2), 32'h1);
    step(); step(); step(); step(); #1;
    chk("r_next_grant", 32'(grant2), 32'h2);
    step(); step(); step(); cctrans2 = 2'b00; #1;
    chk("r_idle_grant", 32'(grant2), 32'h0);

    // single requester back-to-back is regranted every time
    cctrans2 = 2'b10; ccwrite2 = 2'b00; daddr2[1] = 32'hFFFFFFFC;
    step(); #1;
    chk("b2b_grant_a", 32'(grant2), 32'h2);
    step(); #1;
    chk("b2b_dwait", 32'(dwait2), 32'h1);
    chk("b2b_ramaddr0", ramaddr2, 32'hFFFFFFFC);
    step(); #1;
    chk("b2b_ramaddr_wrap", ramaddr2, 32'h0);
    step(); #1;
    chk("b2b_idle_grant", 32'(grant2), 32'h0);
    step(); #1;
    chk("b2b_grant_b", 32'(grant2), 32'h2);
    step(); step(); cctrans2 = 2'b00;

    // four cores request together from rr=0 -> grants 0,1,2,3 in order
    cctrans4 = 4'b1111; ccwrite4 = 4'b0000; ramstate4 = ACCESS;
    for (int g = 0; g < 4; g++) begin
      step(); #1;
      chk("rr4_grant", 32'(grant4), 32'(1 << g));
      step(); #1;
      chk("rr4_ren_wen", {30'd0, ramREN4, ramWEN4}, 32'h2);
      step(); step();
    end
    cctrans4 = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
